// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Write-port controller for the 32x32 register file. Three writeback sources
// share the single write port:
//   - execute stage : fixed top priority, always accepted (no ready)
//   - load unit     : valid/ready, round-robin against debug
//   - debug/loader  : valid/ready, round-robin against load
// The regfile write port is driven from registers (one cycle after the
// transfer). A per-register load-pending scoreboard is kept for load-use
// stall detection in the issue logic.
//
// Ports:
//   i_clk, i_reset_n              clock (rising edge), async active-low reset
//   i_ex_valid/_rd_addr/_rd_data  execute writeback request
//   i_ld_valid/o_ld_ready/...     load writeback handshake
//   i_dbg_valid/o_dbg_ready/...   debug writeback handshake
//   i_ld_issue/_issue_addr        load issue (sets scoreboard bit)
//   o_rd_wren/_addr/_data         registered regfile write port
//   o_grant                       registered one-hot winner {dbg,ld,ex}
//   o_pending                     load-pending scoreboard, bit0 always 0
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_ex_valid,
  input  logic [4:0]      i_ex_rd_addr,
  input  logic [XLEN-1:0] i_ex_rd_data,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [4:0]      i_ld_rd_addr,
  input  logic [XLEN-1:0] i_ld_rd_data,
  input  logic            i_dbg_valid,
  output logic            o_dbg_ready,
  input  logic [4:0]      i_dbg_rd_addr,
  input  logic [XLEN-1:0] i_dbg_rd_data,
  input  logic            i_ld_issue,
  input  logic [4:0]      i_ld_issue_addr,
  output logic            o_rd_wren,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic [2:0]      o_grant,
  output logic [NREG-1:0] o_pending
);

  localparam int AW = 5;

  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_EX   = 3'b001;
  localparam logic [2:0] GNT_LD   = 3'b010;
  localparam logic [2:0] GNT_DBG  = 3'b100;

  logic [2:0]      grant_s;
  logic [AW-1:0]   win_addr_s;
  logic [XLEN-1:0] win_data_s;
  logic            rr_ptr_r;      // 0: load favoured, 1: debug favoured
  logic [NREG-1:0] pending_nxt_s;

  // Per-cycle arbitration: ex wins outright, otherwise ld/dbg with the
  // round-robin pointer breaking a tie.
  always_comb begin
    grant_s = GNT_NONE;
    if (i_ex_valid) begin
      grant_s = GNT_EX;
    end else if (i_ld_valid && i_dbg_valid) begin
      grant_s = rr_ptr_r ? GNT_DBG : GNT_LD;
    end else if (i_ld_valid) begin
      grant_s = GNT_LD;
    end else if (i_dbg_valid) begin
      grant_s = GNT_DBG;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // A ready can only come from a grant, and a grant only from a valid,
  // so ready never rises without its valid.
  assign o_ld_ready  = grant_s[1];
  assign o_dbg_ready = grant_s[2];

  // Select the winning source's address and data.
  always_comb begin
    win_addr_s = {AW{1'b0}};
    win_data_s = {XLEN{1'b0}};
    case (grant_s)
      GNT_EX: begin
        win_addr_s = i_ex_rd_addr;
        win_data_s = i_ex_rd_data;
      end
      GNT_LD: begin
        win_addr_s = i_ld_rd_addr;
        win_data_s = i_ld_rd_data;
      end
      GNT_DBG: begin
        win_addr_s = i_dbg_rd_addr;
        win_data_s = i_dbg_rd_data;
      end
      default: begin
        win_addr_s = {AW{1'b0}};
        win_data_s = {XLEN{1'b0}};
      end
    endcase
  end

  // Scoreboard next state: clear on a load transfer, set on load issue;
  // the set is evaluated first so it wins on a same-register collision.
  always_comb begin
    pending_nxt_s = o_pending;
    for (int n = 1; n < NREG; n++) begin
      if (i_ld_issue && (i_ld_issue_addr == AW'(n))) begin
        pending_nxt_s[n] = 1'b1;
      end else if (grant_s[1] && (i_ld_rd_addr == AW'(n))) begin
        pending_nxt_s[n] = 1'b0;
      end else begin
        pending_nxt_s[n] = o_pending[n];
      end
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Registered write port; address/data hold when nothing transfers,
  // and an x0 winner is reported in o_grant but never written.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= {AW{1'b0}};
      o_rd_data <= {XLEN{1'b0}};
      o_grant   <= GNT_NONE;
    end else if (grant_s != GNT_NONE) begin
      o_rd_wren <= (win_addr_s != {AW{1'b0}});
      o_rd_addr <= win_addr_s;
      o_rd_data <= win_data_s;
      o_grant   <= grant_s;
    end else begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= o_rd_addr;
      o_rd_data <= o_rd_data;
      o_grant   <= GNT_NONE;
    end
  end

  // Round-robin pointer moves only on ld/dbg transfers; ex leaves it alone.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_ptr_r <= 1'b0;
    end else if (grant_s[1]) begin
      rr_ptr_r <= 1'b1;
    end else if (grant_s[2]) begin
      rr_ptr_r <= 1'b0;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Scoreboard register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pending <= {NREG{1'b0}};
    end else begin
      o_pending <= pending_nxt_s;
    end
  end

endmodule
